// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int FETCH_AWIDTH = 15;
    localparam int FETCH_DWIDTH = 32;
    localparam logic [FETCH_AWIDTH-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] addr;
        logic [FETCH_DWIDTH-1:0] word;
    } fetch_entry_t;

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int CW = countWidth(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        entry_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    entry_t        store_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) wrPtr_d = wrPtr_q + PW'(1);
            if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !reset) begin
            store_q[wrPtr_q] <= entry_i;
        end
    end

    assign head_o  = store_q[rdPtr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher with prefetch FIFO and PC redirect.
// Define FETCH_STATS_EN to add issued/flushed/stall counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int AWIDTH = FETCH_AWIDTH,
    parameter int DWIDTH = FETCH_DWIDTH,
    parameter int DEPTH  = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pc_load,
    input  logic [AWIDTH-1:0] pc_target,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              instr_valid,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    input  logic              instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_flushed,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CW = countWidth(DEPTH);

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] word;
    } entry_t;

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] reqAddr_q, reqAddr_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              empty, issue, push, pop;
    entry_t            head, pushEntry;

    // A request is only issued when its response is guaranteed a FIFO slot.
    always_comb begin
        occupancy  = {1'b0, count} + (CW+1)'(inflight_q);
        issue      = !reset && enable && !pc_load && (occupancy < (CW+1)'(DEPTH));
        push       = inflight_q && !pc_load;
        pop        = !empty && instr_ready && !pc_load;
        pc_d       = pc_q;
        reqAddr_d  = reqAddr_q;
        inflight_d = issue;
        if (pc_load) begin
            pc_d = pc_target;
        end else if (issue) begin
            pc_d      = pc_q + AWIDTH'(1);
            reqAddr_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            reqAddr_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            reqAddr_q  <= reqAddr_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        pushEntry      = '0;
        pushEntry.addr = reqAddr_q;
        pushEntry.word = mem_data;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (pc_load),
        .push_i  (push),
        .entry_i (pushEntry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign mem_rd      = issue;
    assign mem_addr    = issue ? pc_q : '0;
    assign instr_valid = !empty;
    assign instr       = empty ? '0 : head.word;
    assign instr_pc    = empty ? '0 : head.addr;

`ifdef FETCH_STATS_EN
    logic [31:0] statIssued_q, statFlushed_q, statStall_q;

    // Flushed count covers both queued entries and the response being dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            statIssued_q  <= '0;
            statFlushed_q <= '0;
            statStall_q   <= '0;
        end else begin
            if (issue) statIssued_q <= statIssued_q + 32'd1;
            if (pc_load) statFlushed_q <= statFlushed_q + 32'(count) + 32'(inflight_q);
            if (enable && !issue && !pc_load) statStall_q <= statStall_q + 32'd1;
        end
    end

    assign stat_issued  = statIssued_q;
    assign stat_flushed = statFlushed_q;
    assign stat_stall   = statStall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a word=addr*3 memory model.
module tb_instr_fetch_unit;

    typedef struct {
        logic        rst, en, rdy, ld;
        logic [14:0] tgt;
        logic        chk, rd;
        logic [14:0] addr;
        logic        v;
        logic [31:0] ins;
        logic [14:0] ipc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, pc_load, instr_ready;
    logic [14:0] pc_target;
    logic        mem_rd, instr_valid;
    logic [14:0] mem_addr, instr_pc;
    logic [31:0] mem_data = '0, instr;

    logic        reset2, enable2, pc_load2, instr_ready2;
    logic [14:0] pc_target2;
    logic        mem_rd2, instr_valid2;
    logic [14:0] mem_addr2, instr_pc2;
    logic [31:0] mem_data2 = '0, instr2;

`ifdef FETCH_STATS_EN
    logic [31:0] statIssued, statFlushed, statStall;
    logic [31:0] statIssued2, statFlushed2, statStall2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .enable(enable), .pc_load(pc_load),
        .pc_target(pc_target), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
        , .stat_issued(statIssued), .stat_flushed(statFlushed), .stat_stall(statStall)
`endif
    );

    instr_fetch_unit #(.RESET_PC(15'h7FFE)) dutWrap (
        .clk(clk), .reset(reset2), .enable(enable2), .pc_load(pc_load2),
        .pc_target(pc_target2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .mem_data(mem_data2), .instr_valid(instr_valid2), .instr(instr2),
        .instr_pc(instr_pc2), .instr_ready(instr_ready2)
`ifdef FETCH_STATS_EN
        , .stat_issued(statIssued2), .stat_flushed(statFlushed2), .stat_stall(statStall2)
`endif
    );

    function automatic logic [31:0] memWord(input logic [14:0] a);
        return 32'(a) * 32'd3;
    endfunction

    always @(posedge clk) begin
        if (mem_rd)  mem_data  <= memWord(mem_addr);
        if (mem_rd2) mem_data2 <= memWord(mem_addr2);
    end

    function automatic vec_t mk(input logic rst, en, rdy, ld, input logic [14:0] tgt,
                                input logic chk, rd, input logic [14:0] addr,
                                input logic v, input logic [31:0] ins, input logic [14:0] ipc);
        vec_t r;
        r.rst = rst; r.en = en; r.rdy = rdy; r.ld = ld; r.tgt = tgt;
        r.chk = chk; r.rd = rd; r.addr = addr; r.v = v; r.ins = ins; r.ipc = ipc;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Outputs are combinational in the inputs, so sample 1 unit after driving at negedge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; enable = v.en; instr_ready = v.rdy;
        pc_load = v.ld; pc_target = v.tgt;
        #1;
        if (v.chk) begin
            checkOutput($sformatf("row%0d memRd", idx), 32'(mem_rd), 32'(v.rd));
            checkOutput($sformatf("row%0d valid", idx), 32'(instr_valid), 32'(v.v));
            if (v.rd || v.rst) checkOutput($sformatf("row%0d memAddr", idx), 32'(mem_addr), 32'(v.addr));
            if (v.v || v.rst) begin
                checkOutput($sformatf("row%0d instr", idx), instr, v.ins);
                checkOutput($sformatf("row%0d instrPc", idx), 32'(instr_pc), 32'(v.ipc));
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [14:0] nextIssue, expPc;
        int delivered;

        reset = 1; enable = 0; pc_load = 0; pc_target = '0; instr_ready = 0;
        reset2 = 1; enable2 = 0; pc_load2 = 0; pc_target2 = '0; instr_ready2 = 0;

        // Streaming from reset with ready high
        vecs.push_back(mk(1,1,1,0,0,     0, 0,0,      0,0,0));
        vecs.push_back(mk(1,1,1,0,0,     1, 0,0,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,0,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,1,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,2,      1,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,3,      1,3,1));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,4,      1,6,2));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,5,      1,9,3));
        // Decode stalled: exactly four reads, then drain and resume at 4
        vecs.push_back(mk(1,1,0,0,0,     0, 0,0,      0,0,0));
        vecs.push_back(mk(1,1,0,0,0,     1, 0,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,1,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,2,      1,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,3,      1,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 0,0,      1,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 0,0,      1,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 0,0,      1,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,4,      1,3,1));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,5,      1,6,2));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,6,      1,9,3));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,7,      1,12,4));
        // Redirect to 0x100 with three queued entries and one in flight
        vecs.push_back(mk(1,1,0,0,0,     0, 0,0,      0,0,0));
        vecs.push_back(mk(1,1,0,0,0,     1, 0,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,1,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,2,      1,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,3,      1,0,0));
        vecs.push_back(mk(0,1,0,1,15'h100,1, 0,0,     1,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,15'h100,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,15'h101,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,15'h102,1,32'h300,15'h100));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,15'h103,1,32'h303,15'h101));
        // Reset while a response is in flight and the FIFO holds three words
        vecs.push_back(mk(1,1,0,0,0,     0, 0,0,      0,0,0));
        vecs.push_back(mk(1,1,0,0,0,     1, 0,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,0,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,1,      0,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,2,      1,0,0));
        vecs.push_back(mk(0,1,0,0,0,     1, 1,3,      1,0,0));
        vecs.push_back(mk(1,1,1,0,0,     0, 0,0,      0,0,0));
        vecs.push_back(mk(1,1,1,0,0,     1, 0,0,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,0,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,1,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,2,      1,0,0));
        // Redirect in the same cycle as a pop and a push
        vecs.push_back(mk(0,1,1,1,5,     1, 0,0,      1,3,1));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,5,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,6,      0,0,0));
        vecs.push_back(mk(0,1,1,0,0,     1, 1,7,      1,15,5));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Enable dropped for five cycles mid-stream with ready toggling
        applyStimulus(mk(1,0,0,0,0, 0, 0,0,0,0,0), 1000);
        applyStimulus(mk(1,0,0,0,0, 0, 0,0,0,0,0), 1001);
        nextIssue = '0; expPc = '0; delivered = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            reset = 0; pc_load = 0;
            enable = !(i >= 10 && i < 15);
            instr_ready = (i % 4 != 3);
            #1;
            if (!enable) checkOutput("enOffMemRd", 32'(mem_rd), 32'd0);
            if (mem_rd) begin
                checkOutput("seqAddr", 32'(mem_addr), 32'(nextIssue));
                nextIssue = nextIssue + 15'd1;
            end
            if (instr_valid && instr_ready) begin
                checkOutput("seqPc", 32'(instr_pc), 32'(expPc));
                checkOutput("seqWord", instr, memWord(expPc));
                expPc = expPc + 15'd1;
                delivered++;
            end
        end
        checkOutput("seqDelivered", 32'(delivered > 15), 32'd1);

        // PC wrap from 0x7FFE on the second instance
        @(negedge clk); reset2 = 1; enable2 = 1; instr_ready2 = 1;
        @(negedge clk);
        nextIssue = 15'h7FFE; expPc = 15'h7FFE; delivered = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset2 = 0;
            #1;
            if (i == 0) checkOutput("wrapFirstRd", 32'(mem_rd2), 32'd1);
            if (mem_rd2) begin
                checkOutput("wrapAddr", 32'(mem_addr2), 32'(nextIssue));
                nextIssue = nextIssue + 15'd1;
            end
            if (instr_valid2 && instr_ready2) begin
                checkOutput("wrapPc", 32'(instr_pc2), 32'(expPc));
                checkOutput("wrapWord", instr2, memWord(expPc));
                expPc = expPc + 15'd1;
                delivered++;
            end
        end
        checkOutput("wrapDelivered", 32'(delivered >= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
